// File: rtl/bus_record_hex_formatter.sv
// Renders captured bus-cycle records as ASCII hex lines for the USART byte stream.
// Optional HEXFMT_INDEX_EN prefixes each line with a 16-bit record index and ':'.
module bus_record_hex_formatter #(
    parameter int CRLF      = 1,
    parameter int UPPER_HEX = 1
) (
    input  logic        comm_clock,
    input  logic        reset_n,
    input  logic        rec_valid,
    output logic        rec_ready,
    input  logic [31:0] rec_addr,
    input  logic [31:0] rec_data,
    input  logic [3:0]  rec_flags,
    input  logic        dump_done,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EMIT    = 2'd1;
    localparam logic [1:0] ST_TRAILER = 2'd2;

`ifdef HEXFMT_INDEX_EN
    localparam int PFX_LEN = 5;
`else
    localparam int PFX_LEN = 0;
`endif
    localparam int TERM_LEN = (CRLF != 0) ? 2 : 1;
    localparam int LINE_LEN = PFX_LEN + 19 + TERM_LEN;
    localparam logic [4:0] LINE_LAST = 5'(LINE_LEN - 1);
    localparam logic [4:0] TRL_LAST  = 5'(3 + TERM_LEN - 1);

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return ((UPPER_HEX != 0) ? 8'h37 : 8'h57) + {4'h0, n};
    endfunction

    function automatic logic [7:0] term_char(input logic second);
        if (second || (CRLF == 0))
            return 8'h0A;
        else
            return 8'h0D;
    endfunction

    // Body layout: addr[0..7] ' ' data[9..16] ' ' flags[18] terminator[19..]
    function automatic logic [7:0] body_byte(input logic [67:0] rec, input logic [4:0] pos);
        logic [2:0] d;
        d = 3'(pos - 5'd9);
        if (pos <= 5'd7)
            return hex_char(4'(rec[67:36] >> {3'd7 - pos[2:0], 2'b00}));
        else if (pos == 5'd8 || pos == 5'd17)
            return 8'h20;
        else if (pos <= 5'd16)
            return hex_char(4'(rec[35:4] >> {3'd7 - d, 2'b00}));
        else if (pos == 5'd18)
            return hex_char(rec[3:0]);
        else
            return term_char(pos != 5'd19);
    endfunction

`ifdef HEXFMT_INDEX_EN
    function automatic logic [7:0] line_byte(input logic [67:0] rec, input logic [15:0] idx,
                                             input logic [4:0] pos);
        if (pos < 5'd4)
            return hex_char(4'(idx >> {2'd3 - pos[1:0], 2'b00}));
        else if (pos == 5'd4)
            return 8'h3A;
        else
            return body_byte(rec, 5'(pos - 5'd5));
    endfunction
`else
    function automatic logic [7:0] line_byte(input logic [67:0] rec, input logic [4:0] pos);
        return body_byte(rec, pos);
    endfunction
`endif

    function automatic logic [7:0] trailer_byte(input logic [4:0] pos);
        case (pos)
            5'd0:    return 8'h45;
            5'd1:    return 8'h4E;
            5'd2:    return 8'h44;
            5'd3:    return term_char(1'b0);
            default: return 8'h0A;
        endcase
    endfunction

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        trl_pend_q, trl_pend_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        rec_ready_q, rec_ready_d;
    logic [67:0] shadow_q;
`ifdef HEXFMT_INDEX_EN
    logic [15:0] idx_q, idx_d;
`endif

    logic        accept;
    logic        tx_hs;
    logic [67:0] rec_sel;
    logic [4:0]  pos_sel;
    logic [7:0]  line_char;
    logic [7:0]  trl_char;

    // In IDLE the first byte comes straight from the inputs so it can be registered
    // in the same cycle the record is accepted; afterwards the shadow copy is used.
    always_comb begin
        rec_sel = (state_q == ST_IDLE) ? {rec_addr, rec_data, rec_flags} : shadow_q;
        pos_sel = (state_q == ST_IDLE) ? 5'd0 : 5'(cnt_q + 5'd1);
`ifdef HEXFMT_INDEX_EN
        line_char = line_byte(rec_sel, idx_q, pos_sel);
`else
        line_char = line_byte(rec_sel, pos_sel);
`endif
        trl_char = trailer_byte(pos_sel);
    end

    assign accept = (state_q == ST_IDLE) && rec_valid && rec_ready_q;
    assign tx_hs  = tx_valid_q && tx_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        trl_pend_d = trl_pend_q | dump_done;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
`ifdef HEXFMT_INDEX_EN
        idx_d      = idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_EMIT;
                    cnt_d      = 5'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = line_char;
                end else if (trl_pend_q) begin
                    state_d    = ST_TRAILER;
                    cnt_d      = 5'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = trl_char;
                end
            end
            ST_EMIT: begin
                if (tx_hs) begin
                    if (cnt_q == LINE_LAST) begin
                        state_d    = ST_IDLE;
                        cnt_d      = 5'd0;
                        tx_valid_d = 1'b0;
`ifdef HEXFMT_INDEX_EN
                        idx_d      = idx_q + 16'd1;
`endif
                    end else begin
                        cnt_d     = 5'(cnt_q + 5'd1);
                        tx_data_d = line_char;
                    end
                end
            end
            ST_TRAILER: begin
                if (tx_hs) begin
                    if (cnt_q == TRL_LAST) begin
                        state_d    = ST_IDLE;
                        cnt_d      = 5'd0;
                        tx_valid_d = 1'b0;
                        trl_pend_d = 1'b0;
`ifdef HEXFMT_INDEX_EN
                        idx_d      = 16'd0;
`endif
                    end else begin
                        cnt_d     = 5'(cnt_q + 5'd1);
                        tx_data_d = trl_char;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cnt_d      = 5'd0;
                tx_valid_d = 1'b0;
            end
        endcase
        rec_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            trl_pend_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            rec_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trl_pend_q  <= trl_pend_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            rec_ready_q <= rec_ready_d;
        end
    end

`ifdef HEXFMT_INDEX_EN
    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n)
            idx_q <= 16'd0;
        else
            idx_q <= idx_d;
    end
`endif

    always_ff @(posedge comm_clock) begin
        if (accept)
            shadow_q <= {rec_addr, rec_data, rec_flags};
    end

    assign rec_ready = rec_ready_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = (state_q != ST_IDLE) || trl_pend_q;

endmodule

// File: tb/tb_bus_record_hex_formatter.sv
// Scoreboard bench for bus_record_hex_formatter: default instance plus a
// lowercase / LF-only instance; expected lines are directed strings.
module tb_bus_record_hex_formatter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        rec_valid_a = 1'b0, rec_valid_b = 1'b0;
    logic [31:0] rec_addr = 32'h0, rec_data = 32'h0;
    logic [3:0]  rec_flags = 4'h0;
    logic        dump_a = 1'b0, dump_b = 1'b0;
    logic        tx_ready_a = 1'b1, tx_ready_b = 1'b1;
    logic        rec_ready_a, rec_ready_b, tx_valid_a, tx_valid_b, busy_a, busy_b;
    logic [7:0]  tx_data_a, tx_data_b;

`ifdef HEXFMT_INDEX_EN
    localparam int PFX = 5;
`else
    localparam int PFX = 0;
`endif
    localparam int LINE_A = PFX + 21;
    localparam int LINE_B = PFX + 20;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int n_cmp = 0, n_err = 0;
    int hs_a = 0, hs_b = 0;
    int idx_a = 0, idx_b = 0;
    bit tog_en = 1'b0;

    always #5 clk = ~clk;

    bus_record_hex_formatter #(.CRLF(1), .UPPER_HEX(1)) dut_a (
        .comm_clock(clk), .reset_n(reset_n), .rec_valid(rec_valid_a), .rec_ready(rec_ready_a),
        .rec_addr(rec_addr), .rec_data(rec_data), .rec_flags(rec_flags), .dump_done(dump_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .busy(busy_a));

    bus_record_hex_formatter #(.CRLF(0), .UPPER_HEX(0)) dut_b (
        .comm_clock(clk), .reset_n(reset_n), .rec_valid(rec_valid_b), .rec_ready(rec_ready_b),
        .rec_addr(rec_addr), .rec_data(rec_data), .rec_flags(rec_flags), .dump_done(dump_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .busy(busy_b));

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic void fail(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event missing or unexpected", name);
    endfunction

    function automatic void push_bytes(bit b, string s);
        for (int i = 0; i < s.len(); i++) begin
            if (b) exp_b.push_back(s[i]);
            else   exp_a.push_back(s[i]);
        end
    endfunction

    function automatic void push_term(bit b);
        if (b) begin
            exp_b.push_back(8'h0A);
        end else begin
            exp_a.push_back(8'h0D);
            exp_a.push_back(8'h0A);
        end
    endfunction

    function automatic void push_line(bit b, string s);
`ifdef HEXFMT_INDEX_EN
        push_bytes(b, $sformatf("%04x:", b ? idx_b : idx_a));
`endif
        push_bytes(b, s);
        push_term(b);
        if (b) idx_b++;
        else   idx_a++;
    endfunction

    function automatic void push_trailer(bit b);
        push_bytes(b, "END");
        push_term(b);
        if (b) idx_b = 0;
        else   idx_a = 0;
    endfunction

    task automatic mon(input bit b);
        bit         stall = 1'b0;
        logic [7:0] held = 8'h00;
        logic [7:0] d, e;
        logic       v, r;
        forever begin
            @(negedge clk);
            v = b ? tx_valid_b : tx_valid_a;
            d = b ? tx_data_b : tx_data_a;
            r = b ? tx_ready_b : tx_ready_a;
            if (!reset_n) begin
                stall = 1'b0;
                continue;
            end
            if (stall)
                check(b ? "hold_b" : "hold_a", {23'd0, v, d}, {23'd0, 1'b1, held});
            if (v && r) begin
                if (b && exp_b.size() == 0) fail("extra_byte_b");
                else if (!b && exp_a.size() == 0) fail("extra_byte_a");
                else begin
                    if (b) e = exp_b.pop_front();
                    else   e = exp_a.pop_front();
                    check(b ? "byte_b" : "byte_a", {24'd0, d}, {24'd0, e});
                end
                if (b) hs_b++;
                else   hs_a++;
            end
            stall = v && !r;
            held  = d;
        end
    endtask

    task automatic toggler();
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) tx_ready_a = ~tx_ready_a;
        end
    endtask

    task automatic send(input bit b, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] f, input bit with_dump, input string s);
        bit got = 1'b0;
        push_line(b, s);
        if (with_dump) push_trailer(b);
        @(posedge clk);
        #1;
        rec_addr = a; rec_data = d; rec_flags = f;
        if (b) rec_valid_b = 1'b1;
        else   rec_valid_a = 1'b1;
        if (with_dump) begin
            if (b) dump_b = 1'b1;
            else   dump_a = 1'b1;
        end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = b ? rec_ready_b : rec_ready_a;
            @(posedge clk);
            #1;
            dump_a = 1'b0;
            dump_b = 1'b0;
        end
        rec_valid_a = 1'b0; rec_valid_b = 1'b0;
        rec_addr = a ^ 32'hA5A5_5A5A; rec_data = ~d; rec_flags = ~f;
        if (!got) fail("rec_accept_timeout");
    endtask

    task automatic wait_idle(input bit b, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (b) ok = !busy_b && !tx_valid_b && exp_b.size() == 0;
            else   ok = !busy_a && !tx_valid_a && exp_a.size() == 0;
        end
        if (!ok) fail(b ? "idle_timeout_b" : "idle_timeout_a");
    endtask

    task automatic wait_hs_a(input int target);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (hs_a >= target) begin
                #1;
                return;
            end
        end
        fail("byte_count_timeout");
    endtask

    task automatic pulse_dump_a();
        dump_a = 1'b1;
        @(posedge clk);
        #1;
        dump_a = 1'b0;
    endtask

    initial begin
        int base, consec, rr_bad, extra;
        fork
            mon(1'b0);
            mon(1'b1);
            toggler();
        join_none

        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rec_ready_a", {31'd0, rec_ready_a}, 32'd0);
        check("rst_tx_valid_a",  {31'd0, tx_valid_a},  32'd0);
        check("rst_tx_data_a",   {24'd0, tx_data_a},   32'd0);
        check("rst_busy_a",      {31'd0, busy_a},      32'd0);
        check("rst_rec_ready_b", {31'd0, rec_ready_b}, 32'd0);
        check("rst_tx_valid_b",  {31'd0, tx_valid_b},  32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic line, tx_ready held high: 21 back-to-back bytes.
        base = hs_a;
        send(1'b0, 32'h0000_1234, 32'hDEAD_BEEF, 4'h5, 1'b0, "00001234 DEADBEEF 5");
        consec = 0; rr_bad = 0;
        for (int i = 0; i < LINE_A; i++) begin
            @(negedge clk);
            if (tx_valid_a) consec++;
            if (rec_ready_a) rr_bad++;
        end
        check("t1_consecutive", consec, LINE_A);
        check("t1_rec_ready_low", rr_bad, 0);
        @(negedge clk);
        check("t1_gap_valid", {31'd0, tx_valid_a}, 32'd0);
        check("t1_busy_after", {31'd0, busy_a}, 32'd0);
        check("t1_byte_count", hs_a - base, LINE_A);

        // Same record with tx_ready toggling every cycle.
        base = hs_a;
        tog_en = 1'b1;
        send(1'b0, 32'h0000_1234, 32'hDEAD_BEEF, 4'h5, 1'b0, "00001234 DEADBEEF 5");
        wait_idle(1'b0, 200);
        tog_en = 1'b0;
        @(posedge clk);
        #1 tx_ready_a = 1'b1;
        check("t2_byte_count", hs_a - base, LINE_A);

        // dump_done at byte 7, then a second dump_done inside the trailer.
        base = hs_a;
        send(1'b0, 32'hCAFE_F00D, 32'h0123_4567, 4'h9, 1'b0, "CAFEF00D 01234567 9");
        wait_hs_a(base + 7);
        push_trailer(1'b0);
        pulse_dump_a();
        wait_hs_a(base + LINE_A + 2);
        pulse_dump_a();
        wait_idle(1'b0, 200);
        check("t3_byte_count", hs_a - base, LINE_A + 5);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_valid_a) extra++;
        end
        check("t3_no_second_trailer", extra, 0);
        check("t3_busy_after", {31'd0, busy_a}, 32'd0);

        // dump_done coincident with record acceptance: line first, then trailer.
        base = hs_a;
        send(1'b0, 32'h89AB_CDEF, 32'hFEDC_BA98, 4'hC, 1'b1, "89ABCDEF FEDCBA98 C");
        wait_idle(1'b0, 200);
        check("t4_byte_count", hs_a - base, LINE_A + 5);

        // Index sequence: three records, trailer, one more record.
        base = hs_a;
        send(1'b0, 32'h1111_1111, 32'h2222_2222, 4'h1, 1'b0, "11111111 22222222 1");
        wait_idle(1'b0, 200);
        send(1'b0, 32'h3333_3333, 32'h4444_4444, 4'h2, 1'b0, "33333333 44444444 2");
        wait_idle(1'b0, 200);
        send(1'b0, 32'h5555_5555, 32'h6666_6666, 4'h3, 1'b0, "55555555 66666666 3");
        wait_idle(1'b0, 200);
        push_trailer(1'b0);
        @(posedge clk);
        #1;
        pulse_dump_a();
        wait_idle(1'b0, 200);
        send(1'b0, 32'h7777_7777, 32'h8888_8888, 4'h4, 1'b0, "77777777 88888888 4");
        wait_idle(1'b0, 200);
        check("t5_byte_count", hs_a - base, 4 * LINE_A + 5);

        // Lowercase hex, LF-only terminator.
        base = hs_b;
        send(1'b1, 32'hABCD_EF01, 32'h89AB_CDEF, 4'hA, 1'b0, "abcdef01 89abcdef a");
        wait_idle(1'b1, 200);
        check("t6_byte_count_b", hs_b - base, LINE_B);

        // Reset in the middle of a line, then a fresh record.
        base = hs_a;
        send(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 4'h3, 1'b0, "12345678 9ABCDEF0 3");
        wait_hs_a(base + 10);
        reset_n = 1'b0;
        @(negedge clk);
        check("t7_rst_tx_valid", {31'd0, tx_valid_a}, 32'd0);
        check("t7_rst_tx_data", {24'd0, tx_data_a}, 32'd0);
        check("t7_rst_rec_ready", {31'd0, rec_ready_a}, 32'd0);
        check("t7_rst_busy", {31'd0, busy_a}, 32'd0);
        exp_a.delete();
        exp_b.delete();
        idx_a = 0;
        idx_b = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("t7_post_rst_valid", {31'd0, tx_valid_a}, 32'd0);
        base = hs_a;
        send(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 4'hF, 1'b0, "FFFFFFFF 00000000 F");
        wait_idle(1'b0, 200);
        check("t7_byte_count", hs_a - base, LINE_A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
